pwm_n_capture: RTL and testbench

Receive-side counterpart of the n-bit PWM generator. Samples an asynchronous PWM input, measures the period and high time of each cycle in clk_i ticks, and publishes them with a one-cycle valid strobe. It also flags a stuck line (0 % or 100 % duty, or a disconnected source) after a programmable timeout. It sits at the board input or in loopback from pwm_n, and feeds control or monitor logic.

---
 rtl/pwm_n_capture.sv | 120 ++++++++++++
 tb/tb_pwm_n_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_n_capture.sv
// pwm_n_capture: measures period and high time of an asynchronous PWM input and flags a stuck line.
// Optional `define PWM_CAP_GLITCH_FILTER_EN inserts a FILT-clock stability filter after the synchronizer.
module pwm_n_capture #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned FILT    = 3
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             pwm_i,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             valid_o,
   output logic             stuck_o,
   output logic             level_o
);

   typedef enum logic [1:0] {IDLE, MEAS, STUCK} state_t;

   state_t           state;
   logic             sync1, sync2, s, s_d;
   logic             rise, timeout;
   logic [CNT_W-1:0] per_cnt, hi_cnt;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= pwm_i;
         sync2 <= sync1;
      end
   end

`ifdef PWM_CAP_GLITCH_FILTER_EN
   localparam int unsigned FW = (FILT > 1) ? $clog2(FILT) : 1;
   logic [FW-1:0] filt_cnt;

   // s follows sync2 only after FILT consecutive clocks at the new level
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         s        <= 1'b0;
         filt_cnt <= '0;
      end else if (sync2 == s) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT - 1)) begin
         s        <= sync2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end
`else
   assign s = sync2;
`endif

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) s_d <= 1'b0;
      else           s_d <= s;
   end

   assign rise    = s & ~s_d;
   assign timeout = (per_cnt >= CNT_W'(TIMEOUT));

   // Saturating counters; frozen while stuck so the timeout is not re-declared
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (rise) begin
         per_cnt <= CNT_W'(1);
         hi_cnt  <= CNT_W'(1);
      end else if (state != STUCK) begin
         if (per_cnt != '1)
            per_cnt <= per_cnt + CNT_W'(1);
         if (s && (hi_cnt != '1))
            hi_cnt <= hi_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state    <= IDLE;
         period_o <= '0;
         high_o   <= '0;
         valid_o  <= 1'b0;
         stuck_o  <= 1'b0;
         level_o  <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            IDLE, MEAS: begin
               if (rise) begin
                  state <= MEAS;
                  // the period that ends here only counts if its start edge was measured
                  if (state == MEAS) begin
                     period_o <= per_cnt;
                     high_o   <= hi_cnt;
                     stuck_o  <= 1'b0;
                     valid_o  <= 1'b1;
                  end
               end else if (timeout) begin
                  state    <= STUCK;
                  period_o <= '0;
                  high_o   <= '0;
                  stuck_o  <= 1'b1;
                  level_o  <= s;
                  valid_o  <= 1'b1;
               end
            end
            STUCK: begin
               if (rise)
                  state <= MEAS;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_n_capture.sv
// Testbench for pwm_n_capture: directed and random PWM waveforms checked cycle by cycle
// against an event-level reference model built from the history of driven line levels.
module tb_pwm_n_capture;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 64;
   localparam int FILT    = 3;
   localparam int MAXE    = 20000;

   logic             clk_i = 1'b0;
   logic             resetn_i;
   logic             pwm_i;
   logic [CNT_W-1:0] period_o, high_o;
   logic             valid_o, stuck_o, level_o;

   pwm_n_capture #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT),
      .FILT    (FILT)
   ) dut (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .pwm_i    (pwm_i),
      .period_o (period_o),
      .high_o   (high_o),
      .valid_o  (valid_o),
      .stuck_o  (stuck_o),
      .level_o  (level_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // lv[e]: pwm level sampled at edge e; sh[e]: conditioned line level seen at edge e
   bit lv [MAXE];
   bit sh [MAXE];
   int e    = 0;
   int base = 0;

   bit               have_prev, stuck_flag;
   int               last_rise, timer_ref;
   logic [CNT_W-1:0] x_per, x_hi;
   bit               x_stuck, x_level, x_valid;
   bit               fs;
   int               fcnt;

   function automatic bit lvat(input int i);
      return (i <= base) ? 1'b0 : lv[i];
   endfunction

   function automatic int count_high(input int from, input int to_excl);
      int c = 0;
      for (int i = from; i < to_excl; i++) c += int'(sh[i]);
      return c;
   endfunction

   task automatic model_reset();
      base       = e;
      timer_ref  = e;
      have_prev  = 1'b0;
      stuck_flag = 1'b0;
      x_per      = '0;
      x_hi       = '0;
      x_stuck    = 1'b0;
      x_level    = 1'b0;
      x_valid    = 1'b0;
      fs         = 1'b0;
      fcnt       = 0;
   endtask

   // Expected outputs after edge e, from rise times and gaps in the level history
   task automatic model_edge();
      bit raw, rise;
      raw = lvat(e - 2);
`ifdef PWM_CAP_GLITCH_FILTER_EN
      sh[e] = fs;
      if (raw != fs) begin
         if (fcnt == FILT - 1) begin
            fs   = raw;
            fcnt = 0;
         end else begin
            fcnt++;
         end
      end else begin
         fcnt = 0;
      end
`else
      sh[e] = raw;
`endif
      rise    = sh[e] && !sh[e-1];
      x_valid = 1'b0;
      if (rise) begin
         if (have_prev && !stuck_flag) begin
            x_per   = CNT_W'(e - last_rise);
            x_hi    = CNT_W'(count_high(last_rise, e));
            x_stuck = 1'b0;
            x_valid = 1'b1;
         end
         have_prev  = 1'b1;
         stuck_flag = 1'b0;
         last_rise  = e;
         timer_ref  = e;
      end else if (!stuck_flag && (e - timer_ref == TIMEOUT)) begin
         stuck_flag = 1'b1;
         x_valid    = 1'b1;
         x_stuck    = 1'b1;
         x_level    = sh[e];
         x_per      = '0;
         x_hi       = '0;
      end
   endtask

   task automatic check_outputs();
      checks++;
      assert (valid_o === x_valid) else begin
         errors++;
         $error("FAIL valid e=%0d observed=%b expected=%b", e, valid_o, x_valid);
      end
      checks++;
      assert ({period_o, high_o, stuck_o, level_o} === {x_per, x_hi, x_stuck, x_level}) else begin
         errors++;
         $error("FAIL outputs e=%0d observed per=%0d hi=%0d stuck=%b level=%b expected per=%0d hi=%0d stuck=%b level=%b",
                e, period_o, high_o, stuck_o, level_o, x_per, x_hi, x_stuck, x_level);
      end
   endtask

   task automatic step(input bit b);
      pwm_i = b;
      @(posedge clk_i);
      e++;
      if (e >= MAXE) begin
         $display("FAIL history_overflow e=%0d limit=%0d", e, MAXE);
         $fatal(1, "history overflow");
      end
      lv[e] = b;
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic hold(input bit b, input int n);
      for (int i = 0; i < n; i++) step(b);
   endtask

   task automatic wave(input int per, input int hi, input int n);
      for (int p = 0; p < n; p++)
         for (int i = 0; i < per; i++) step(i < hi);
   endtask

   // period-16/high-4 cycle with a glitch of glen clocks in the low phase
   task automatic glitch_period(input int glen);
      for (int i = 0; i < 16; i++) step((i < 4) || ((i >= 9) && (i < 9 + glen)));
   endtask

   task automatic rst_pulse(input int n);
      #1 resetn_i = 1'b0;
      #1;
      checks++;
      assert ({period_o, high_o, valid_o, stuck_o, level_o} === '0) else begin
         errors++;
         $error("FAIL async_reset observed per=%0d hi=%0d valid=%b stuck=%b level=%b expected all 0",
                period_o, high_o, valid_o, stuck_o, level_o);
      end
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         e++;
         lv[e] = pwm_i;
         sh[e] = 1'b0;
      end
      #1 resetn_i = 1'b1;
      model_reset();
   endtask

   initial begin
      resetn_i = 1'b0;
      pwm_i    = 1'b0;
      model_reset();
      #50;
      checks++;
      assert ({period_o, high_o, valid_o, stuck_o, level_o} === '0) else begin
         errors++;
         $error("FAIL reset_state observed per=%0d hi=%0d valid=%b stuck=%b level=%b expected all 0",
                period_o, high_o, valid_o, stuck_o, level_o);
      end
      @(posedge clk_i);
      #1 resetn_i = 1'b1;
      model_reset();

      // nominal 16/4 stream, first period discarded
      wave(16, 4, 6);

      // duty sweep on period 16
      for (int h = 0; h <= 16; h++) wave(16, h, 3);

      // stuck low, then stuck high
      hold(1'b0, TIMEOUT + 20);
      wave(16, 4, 3);
      hold(1'b1, TIMEOUT + 20);

      // recovery after stuck
      wave(10, 3, 4);

      // period exactly TIMEOUT still publishes; minimum period 2
      wave(TIMEOUT, 10, 3);
      wave(2, 1, 8);

      // one-clock reset in the middle of a period
      wave(10, 3, 2);
      hold(1'b1, 3);
      hold(1'b0, 2);
      rst_pulse(1);
      wave(10, 3, 4);

      // glitches on a 16/4 stream
      wave(16, 4, 3);
      glitch_period(1);
      wave(16, 4, 2);
      glitch_period(2);
      wave(16, 4, 3);

      // random periods and duties, some beyond the timeout, occasional resets
      for (int i = 0; i < 40; i++) begin
         int per, hi;
         per = int'($urandom_range(2, TIMEOUT + 10));
         hi  = int'($urandom_range(0, per));
         if ($urandom_range(0, 9) == 0) rst_pulse(int'($urandom_range(1, 3)));
         wave(per, hi, int'($urandom_range(1, 4)));
      end
      hold(1'b0, TIMEOUT + 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
